pong_score: RTL and testbench
=============================

# pong_score

Score and match controller for the Pong design, directly upstream of the six-digit seven-segment decoder. It counts points for both players, sequences serve/play/game-over, and drives the six 4-bit digit codes the decoder turns into HEX0–HEX5. Codes 0–9 display digits; any code 10–15 blanks a digit.

## Interface
Parameters:
- WIN_SCORE, 11, points needed to win; legal range 1..99.
- SERVE_DELAY, 50_000_000, cycles the ball is held before each serve (1 s at 50 MHz); ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock; all state cleared immediately on assertion.
- start  in  1  debounced level from the start key; acted on at its rising edge.
- p1_point  in  1  one-cycle pulse from ball logic: player 1 scored.
- p2_point  in  1  one-cycle pulse: player 2 scored.
- serve_ok  out  1  high while the ball may move (PLAY only).
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 P1, 10 P2.
- seg0..seg5  out  4 each  digit codes for HEX0..HEX5.

## Operation
- States: IDLE, SERVE, PLAY, OVER. Reset → IDLE.
- Start edge: start_q registers start; edge = start & ~start_q. start_q resets to 1, so a key held through reset never produces an edge.
- IDLE: on edge → SERVE, clear both scores, load delay counter with SERVE_DELAY-1.
- SERVE: decrement counter; when counter = 0 → PLAY. Point pulses ignored.
- PLAY: p1_point alone → P1 +1; p2_point alone → P2 +1; both in same cycle → ignored, stay PLAY. After a counted point: if new score = WIN_SCORE → OVER and set winner; else → SERVE with counter reloaded.
- OVER: scores frozen; winner held. Start edge → SERVE, scores cleared, winner = 00.
- Start edge in SERVE or PLAY: ignored.
- Score per player: 7-bit binary count for the win compare, plus two-digit BCD (ones wraps 9→0 carrying into tens; tens saturates at 9, 99 holds).
- Digit map: seg5/seg4 = P1 tens/ones; seg1/seg0 = P2 tens/ones; tens = 0 shows blank (4'hF); ones always shown. seg3 = 4'hF always; seg2 = 4'hF except in OVER, where it is 1 or 2 (winner).

## Timing
- Reset values: state IDLE, scores 0, serve_ok 0, game_over 0, winner 00, seg0 = seg4 = 0, seg1 = seg2 = seg3 = seg5 = 4'hF.
- All outputs registered. A pulse sampled at edge N updates the score, state and seg outputs at edge N (visible the cycle after the pulse). serve_ok drops on the same edge.
- A start edge in IDLE/OVER sampled at edge N gives state SERVE after edge N. serve_ok rises exactly SERVE_DELAY cycles after entering SERVE.
- reset asserted mid-SERVE or mid-PLAY forces reset values immediately and asynchronously. There is no partial update.

## Structure
- Package pong_pkg:
  - state enum;
  - BLANK = 4'hF;
  - winner codes;
  - score width constant (7).
- Sub-module bcd_counter2: two-digit BCD counter with clear, increment and saturate at 99, plus a parallel 7-bit binary count. It is instantiated once per player.
- Top: FSM, delay counter, start edge detector, digit mapping.

## Test plan
- Bench uses SERVE_DELAY = 4 and WIN_SCORE = 11.
- Reset with start held high, then release and raise it again → no transition until the real rising edge. Afterwards state SERVE, and serve_ok rises 4 cycles later.
- In PLAY, 10 pulses on p1_point, each followed by a serve → seg5 = 1, seg4 = 0, seg1 = F, seg0 = 0. serve_ok is low for 4 cycles after each point.
- P1 at 10, one more p1_point → game_over = 1, winner = 01, seg2 = 1. Further point pulses leave the scores unchanged.
- p1_point and p2_point in the same PLAY cycle → both scores unchanged, state stays PLAY, serve_ok stays 1.
- Point pulses during SERVE and IDLE → ignored. A start edge in OVER → scores 0, seg2 = F, winner = 00, state SERVE.
- reset asserted mid-SERVE countdown → all outputs at reset values before the next clk edge.
- Separate bcd_counter2 unit test with 120 increments → saturates at 9/9.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong score/match controller.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_OVER
   } state_t;

   localparam logic [3:0] BLANK    = 4'hF;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam int         SCORE_W  = 7;

   // Leading zero of a two-digit score is blanked.
   function automatic logic [3:0] tens_code(input logic [3:0] t);
      return (t == 4'd0) ? BLANK : t;
   endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD point counter, saturating at 99, with a parallel binary count.
module bcd_counter2
   import pong_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [3:0]         tens_nx_o,
   output logic [3:0]         ones_nx_o,
   output logic [SCORE_W-1:0] bin_o
);

   logic [3:0]         tens_q, tens_d;
   logic [3:0]         ones_q, ones_d;
   logic [SCORE_W-1:0] bin_q, bin_d;
   logic               full;

   assign full = (tens_q == 4'd9) && (ones_q == 4'd9);

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      bin_d  = bin_q;
      if (clr) begin
         tens_d = 4'd0;
         ones_d = 4'd0;
         bin_d  = '0;
      end else if (inc && !full) begin
         bin_d = bin_q + SCORE_W'(1);
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens_q <= 4'd0;
         ones_q <= 4'd0;
         bin_q  <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
         bin_q  <= bin_d;
      end
   end

   // Next-state digits let the parent register its display on the same edge.
   assign tens_nx_o = tens_d;
   assign ones_nx_o = ones_d;
   assign bin_o     = bin_q;

endmodule

// File: rtl/pong_score.sv
// Pong match controller: serve/play/over sequencing, scoring, digit codes.
module pong_score
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_DELAY = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       p1_point,
   input  logic       p2_point,
   output logic       serve_ok,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [3:0] seg0,
   output logic [3:0] seg1,
   output logic [3:0] seg2,
   output logic [3:0] seg3,
   output logic [3:0] seg4,
   output logic [3:0] seg5
);

   localparam int CW = $clog2(SERVE_DELAY + 1);
   localparam logic [CW-1:0] RELOAD = CW'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         winner_q, winner_d;
   logic               start_q, start_edge;
   logic               clr, inc1, inc2;
   logic               serve_ok_q, game_over_q;
   logic [3:0]         seg0_q, seg1_q, seg2_q, seg4_q, seg5_q;
   logic [3:0]         t1, o1, t2, o2;
   logic [SCORE_W-1:0] b1, b2;

   assign start_edge = start & ~start_q;

   bcd_counter2 u_p1 (
      .clk(clk), .rst(reset), .clr(clr), .inc(inc1),
      .tens_nx_o(t1), .ones_nx_o(o1), .bin_o(b1)
   );

   bcd_counter2 u_p2 (
      .clk(clk), .rst(reset), .clr(clr), .inc(inc2),
      .tens_nx_o(t2), .ones_nx_o(o2), .bin_o(b2)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      clr      = 1'b0;
      inc1     = 1'b0;
      inc2     = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_edge) begin
               state_d  = ST_SERVE;
               cnt_d    = RELOAD;
               winner_d = WIN_NONE;
               clr      = 1'b1;
            end
         end
         ST_SERVE: begin
            if (cnt_q == '0) state_d = ST_PLAY;
            else cnt_d = cnt_q - CW'(1);
         end
         ST_PLAY: begin
            // Simultaneous points cancel out; play continues.
            if (p1_point ^ p2_point) begin
               inc1  = p1_point;
               inc2  = p2_point;
               state_d = ST_SERVE;
               cnt_d   = RELOAD;
               if (p1_point && (b1 + SCORE_W'(1) == WIN)) begin
                  state_d  = ST_OVER;
                  winner_d = WIN_P1;
               end
               if (p2_point && (b2 + SCORE_W'(1) == WIN)) begin
                  state_d  = ST_OVER;
                  winner_d = WIN_P2;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         winner_q    <= WIN_NONE;
         start_q     <= 1'b1;
         serve_ok_q  <= 1'b0;
         game_over_q <= 1'b0;
         seg0_q      <= 4'd0;
         seg1_q      <= BLANK;
         seg2_q      <= BLANK;
         seg4_q      <= 4'd0;
         seg5_q      <= BLANK;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         winner_q    <= winner_d;
         start_q     <= start;
         serve_ok_q  <= (state_d == ST_PLAY);
         game_over_q <= (state_d == ST_OVER);
         seg0_q      <= o2;
         seg1_q      <= tens_code(t2);
         seg2_q      <= (state_d == ST_OVER) ? {2'b00, winner_d} : BLANK;
         seg4_q      <= o1;
         seg5_q      <= tens_code(t1);
      end
   end

   assign serve_ok  = serve_ok_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign seg0      = seg0_q;
   assign seg1      = seg1_q;
   assign seg2      = seg2_q;
   assign seg3      = BLANK;
   assign seg4      = seg4_q;
   assign seg5      = seg5_q;

endmodule

// File: tb/tb_pong_score.sv
// Scoreboard bench for pong_score and a standalone bcd_counter2.
module tb_pong_score;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b1;
   logic       p1 = 1'b0;
   logic       p2 = 1'b0;
   logic       serve_ok, game_over;
   logic [1:0] winner;
   logic [3:0] s0, s1, s2, s3, s4, s5;

   logic       bclr = 1'b0;
   logic       binc = 1'b0;
   logic [3:0] bt, bo;
   logic [6:0] bb;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      bit          kind;
      logic        so;
      logic        go;
      logic [1:0]  win;
      logic [23:0] segs;
      logic [3:0]  bt;
      logic [3:0]  bo;
      logic [6:0]  bb;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pong_score #(.WIN_SCORE(11), .SERVE_DELAY(4)) dut (
      .clk(clk), .reset(rst), .start(start),
      .p1_point(p1), .p2_point(p2),
      .serve_ok(serve_ok), .game_over(game_over), .winner(winner),
      .seg0(s0), .seg1(s1), .seg2(s2), .seg3(s3), .seg4(s4), .seg5(s5)
   );

   bcd_counter2 u_bcd (
      .clk(clk), .rst(rst), .clr(bclr), .inc(binc),
      .tens_nx_o(bt), .ones_nx_o(bo), .bin_o(bb)
   );

   function automatic logic [23:0] mk_segs(int a, int b, logic [1:0] w);
      logic [3:0] a10, b10, s2e;
      a10 = (a / 10 == 0) ? 4'hF : 4'(a / 10);
      b10 = (b / 10 == 0) ? 4'hF : 4'(b / 10);
      s2e = (w == 2'b00) ? 4'hF : {2'b00, w};
      return {a10, 4'(a % 10), 4'hF, s2e, b10, 4'(b % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_top(string nm, logic so, logic go,
                           logic [1:0] w, int a, int b);
      exp_t e;
      e.name = nm; e.kind = 1'b0; e.so = so; e.go = go; e.win = w;
      e.segs = mk_segs(a, b, w);
      e.bt = '0; e.bo = '0; e.bb = '0;
      sb.push_back(e);
   endtask

   task automatic push_bcd(string nm, logic [3:0] t, logic [3:0] o,
                           logic [6:0] b);
      exp_t e;
      e.name = nm; e.kind = 1'b1; e.so = 0; e.go = 0; e.win = 0;
      e.segs = '0; e.bt = t; e.bo = o; e.bb = b;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [23:0] act;
         e = sb.pop_front();
         n_chk++;
         if (e.kind == 1'b0) begin
            act = {s5, s4, s3, s2, s1, s0};
            if (serve_ok !== e.so || game_over !== e.go ||
                winner !== e.win || act !== e.segs) begin
               n_fail++;
               $display("FAIL %s: got so=%b go=%b win=%b segs=%h, want so=%b go=%b win=%b segs=%h",
                        e.name, serve_ok, game_over, winner, act,
                        e.so, e.go, e.win, e.segs);
            end
         end else begin
            if (bt !== e.bt || bo !== e.bo || bb !== e.bb) begin
               n_fail++;
               $display("FAIL %s: got %0d%0d bin=%0d, want %0d%0d bin=%0d",
                        e.name, bt, bo, bb, e.bt, e.bo, e.bb);
            end
         end
      end
   end

   int e1 = 0;
   int e2 = 0;

   // Checks the 4-cycle hold after entering SERVE, optionally with stray points.
   task automatic serve_check(string nm, bit noise);
      for (int k = 0; k < 4; k++) begin
         push_top(nm, 1'b0, 1'b0, 2'b00, e1, e2);
         p1 = noise && (k == 1);
         p2 = noise && (k == 2);
         tick();
         p1 = 1'b0;
         p2 = 1'b0;
      end
      push_top({nm, "_play"}, 1'b1, 1'b0, 2'b00, e1, e2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) tick();
      push_top("reset", 1'b0, 1'b0, 2'b00, 0, 0);
      tick();
      rst = 1'b0;
      repeat (6) tick();
      push_top("held_start", 1'b0, 1'b0, 2'b00, 0, 0);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      serve_check("first_serve", 1'b0);

      for (int i = 0; i < 10; i++) begin
         p1 = 1'b1;
         tick();
         p1 = 1'b0;
         e1++;
         serve_check("p1_point", 1'b0);
      end

      p1 = 1'b1;
      p2 = 1'b1;
      tick();
      p1 = 1'b0;
      p2 = 1'b0;
      push_top("both_points", 1'b1, 1'b0, 2'b00, e1, e2);

      p2 = 1'b1;
      tick();
      p2 = 1'b0;
      e2++;
      serve_check("p2_serve_noise", 1'b1);

      p1 = 1'b1;
      tick();
      p1 = 1'b0;
      e1++;
      push_top("p1_wins", 1'b0, 1'b1, 2'b01, e1, e2);
      p1 = 1'b1;
      tick();
      p1 = 1'b0;
      p2 = 1'b1;
      tick();
      p2 = 1'b0;
      push_top("over_frozen", 1'b0, 1'b1, 2'b01, e1, e2);

      start = 1'b1;
      tick();
      start = 1'b0;
      e1 = 0;
      e2 = 0;
      push_top("restart", 1'b0, 1'b0, 2'b00, 0, 0);
      tick();
      #1;
      rst = 1'b1;
      push_top("async_reset", 1'b0, 1'b0, 2'b00, 0, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      tick();
      p1 = 1'b1;
      tick();
      p1 = 1'b0;
      p2 = 1'b1;
      tick();
      p2 = 1'b0;
      push_top("idle_points", 1'b0, 1'b0, 2'b00, 0, 0);

      bclr = 1'b1;
      tick();
      bclr = 1'b0;
      for (int i = 1; i <= 120; i++) begin
         binc = 1'b1;
         tick();
         binc = 1'b0;
         if (i == 9 || i == 10 || i == 99 || i == 120) begin
            case (i)
               9:       push_bcd("bcd_9", 4'd0, 4'd9, 7'd9);
               10:      push_bcd("bcd_10", 4'd1, 4'd0, 7'd10);
               99:      push_bcd("bcd_99", 4'd9, 4'd9, 7'd99);
               default: push_bcd("bcd_sat", 4'd9, 4'd9, 7'd99);
            endcase
            tick();
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
